// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_pkg
//  Description : Shared fetch-path definitions: default widths, PC stride,
//                NOP encoding and the fetch-buffer entry layout.
//  Revision    : 1.0  initial release
// ============================================================================
package arm_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    // Fixed 32-bit instruction stride.
    localparam int unsigned PC_INC  = 4;

    // Value presented to decode whenever the fetch buffer is empty.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // One fetch-buffer entry.
    // The instruction sits in the upper bits and the return address (pc+4)
    // sits in the lower bits, so a packed {instr, pc_plus4} vector has this
    // same layout.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_plus4;
    } fetch_entry_t;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/if_instr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : if_instr_fifo
//  Description : Synchronous circular fetch buffer with push, pop and flush.
//                A push and a pop in the same cycle are both honoured even
//                when the buffer is full. In that case the freed head slot
//                takes the new word and the level does not change.
//  Ports       : clk      - clock, rising edge
//                rst_n    - synchronous active-low reset (empties buffer)
//                push_i   - write wdata_i at tail
//                pop_i    - retire head entry
//                flush_i  - discard all entries (overrides push/pop)
//                wdata_i  - entry to write
//                rdata_o  - head entry (registered storage)
//                valid_o  - buffer non-empty
//                full_o   - buffer holds DEPTH entries
//                level_o  - current occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module if_instr_fifo
    import arm_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = $bits(fetch_entry_t)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [LVL_W-1:0] level_q;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;

    assign w_empty = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign valid_o = ~w_empty;
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Qualify the requests here so that the buffer state cannot be
    // corrupted by an over- or under-run.
    // A write into a full buffer is legal only while the head is leaving.
    assign w_pop  = pop_i & ~w_empty;
    assign w_push = push_i & (~full_o | w_pop);

    // Pointers and level. DEPTH is a power of two, so the pointers wrap
    // naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // The storage is not reset. Stale contents are never observable,
    // because visibility is controlled entirely by level_q.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule : if_instr_fifo
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Fetch stage front end.
//                - Owns the PC and presents it to a combinational
//                  instruction memory.
//                - Buffers each returned word together with pc+4 in
//                  if_instr_fifo.
//                - Hands buffered words to decode with a valid/ready
//                  handshake.
//                - A taken branch flushes the buffer and redirects the PC.
//  Options     : IF_PERF_CNT_EN - when defined, adds the saturating
//                perf_stall_cnt / perf_flush_cnt outputs.
//  Ports       : clk, rst_n     - clock / synchronous active-low reset
//                imem_addr      - current PC (word aligned)
//                imem_instr     - word returned for imem_addr, same cycle
//                branch_taken   - redirect request (highest priority)
//                branch_addr    - redirect target, bits [1:0] ignored
//                id_valid       - head entry valid
//                id_ready       - decode accepts head
//                id_instr       - head instruction (0 when invalid)
//                id_pc          - head pc+4 (0 when invalid)
//                fifo_level     - buffer occupancy
//                perf_stall_cnt - cycles full, not popping, no branch
//                perf_flush_cnt - branch cycles that discarded entries
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_unit
    import arm_pkg::*;
#(
    parameter int unsigned        ADDR_W     = arm_pkg::ADDR_W,
    parameter int unsigned        INSTR_W    = arm_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int unsigned        FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [ADDR_W-1:0]             imem_addr,
    input  logic [INSTR_W-1:0]            imem_instr,
    input  logic                          branch_taken,
    input  logic [ADDR_W-1:0]             branch_addr,
    output logic                          id_valid,
    input  logic                          id_ready,
    output logic [INSTR_W-1:0]            id_instr,
    output logic [ADDR_W-1:0]             id_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_stall_cnt,
    output logic [31:0]                   perf_flush_cnt
`endif
);

    localparam int unsigned       ENTRY_W      = INSTR_W + ADDR_W;
    localparam logic [ADDR_W-1:0] RESET_PC_ALN = {RESET_PC[ADDR_W-1:2], 2'b00};

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  branch_tgt;

    logic               push;
    logic               pop;
    logic               fifo_valid;
    logic               fifo_full;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_head;

    // The target is always word aligned, so the two low bits of
    // branch_addr carry no information.
    logic [1:0]         unused_branch_lsbs;
    assign unused_branch_lsbs = branch_addr[1:0];

    assign branch_tgt = {branch_addr[ADDR_W-1:2], 2'b00};
    assign pc_plus4   = pc_q + ADDR_W'(PC_INC);
    assign imem_addr  = pc_q;

    // Decode handshake and fetch acceptance.
    // A branch blocks the fetch, so the word on imem_instr in that cycle is
    // dropped.
    assign pop  = fifo_valid & id_ready;
    assign push = ~branch_taken & (~fifo_full | pop);

    // Next PC. A branch wins over advancing.
    // Without a push the PC holds, so the same address is presented again
    // in the next cycle.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_tgt;
        end else if (push) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC_ALN;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign fifo_wdata = {imem_instr, pc_plus4};

    if_instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop & ~branch_taken),
        .flush_i (branch_taken),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .valid_o (fifo_valid),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    // Gate the head so that decode sees zeros while the buffer is empty.
    assign id_valid = fifo_valid;
    assign id_instr = fifo_valid ? fifo_head[ADDR_W +: INSTR_W] : INSTR_W'(NOP_INSTR);
    assign id_pc    = fifo_valid ? fifo_head[ADDR_W-1:0]        : '0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        stall_evt;
    logic        flush_evt;

    assign stall_evt = fifo_full & ~pop & ~branch_taken;
    assign flush_evt = branch_taken & (fifo_level != '0);

    // Both counters stop at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_evt && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule : if_fetch_unit
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Directed bench for if_fetch_unit. Two instances are used:
//                u_dut0 with RESET_PC=0 and u_dut1 with RESET_PC=0xFFFFFFF8.
//                The instruction memory model returns 0xA0 + address.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance 0 signals ----------------
    logic        rst_n0;
    logic [31:0] addr0;
    logic [31:0] instr0;
    logic        br0;
    logic [31:0] bra0;
    logic        val0;
    logic        rdy0;
    logic [31:0] idi0;
    logic [31:0] idp0;
    logic [1:0]  lvl0;

    // ---------------- instance 1 signals ----------------
    logic        rst_n1;
    logic [31:0] addr1;
    logic [31:0] instr1;
    logic        br1;
    logic [31:0] bra1;
    logic        val1;
    logic        rdy1;
    logic [31:0] idi1;
    logic [31:0] idp1;
    logic [1:0]  lvl1;

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall0;
    logic [31:0] flush0;
    logic [31:0] stall1;
    logic [31:0] flush1;
`endif

    assign instr0 = 32'hA0 + addr0;
    assign instr1 = 32'hA0 + addr1;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n0),
        .imem_addr    (addr0),
        .imem_instr   (instr0),
        .branch_taken (br0),
        .branch_addr  (bra0),
        .id_valid     (val0),
        .id_ready     (rdy0),
        .id_instr     (idi0),
        .id_pc        (idp0),
        .fifo_level   (lvl0)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_stall_cnt (stall0),
        .perf_flush_cnt (flush0)
`endif
    );

    if_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n1),
        .imem_addr    (addr1),
        .imem_instr   (instr1),
        .branch_taken (br1),
        .branch_addr  (bra1),
        .id_valid     (val1),
        .id_ready     (rdy1),
        .id_instr     (idi1),
        .id_pc        (idp1),
        .fifo_level   (lvl1)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_stall_cnt (stall1),
        .perf_flush_cnt (flush1)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n0 = 1'b0; rdy0 = 1'b0; br0 = 1'b0; bra0 = 32'h0;
        rst_n1 = 1'b0; rdy1 = 1'b1; br1 = 1'b0; bra1 = 32'h0;
        tick();
        tick();

        // ---- reset state ----
        check("rst_addr",  addr0, 32'h0);
        check("rst_valid", {31'h0, val0}, 32'h0);
        check("rst_instr", idi0, 32'h0);
        check("rst_pc",    idp0, 32'h0);
        check("rst_level", {30'h0, lvl0}, 32'h0);

        // ---- streaming with decode always ready ----
        rst_n0 = 1'b1; rdy0 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("strm_pc",    idp0, 32'(4 * k));
            check("strm_instr", idi0, 32'hA0 + 32'(4 * (k - 1)));
            check("strm_addr",  addr0, 32'(4 * k));
            check("strm_level", {30'h0, lvl0}, 32'd1);
        end

        // ---- stall: decode not ready for 5 cycles ----
        rst_n0 = 1'b0; rdy0 = 1'b0;
        tick();
        rst_n0 = 1'b1;
        tick();
        check("stall_lvl1", {30'h0, lvl0}, 32'd1);
        tick();
        check("stall_lvl2", {30'h0, lvl0}, 32'd2);
        check("stall_addr", addr0, 32'h8);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold_addr", addr0, 32'h8);
            check("stall_hold_lvl",  {30'h0, lvl0}, 32'd2);
            check("stall_head_pc",   idp0, 32'h4);
        end

        // ---- full with decode ready: pass-through, no bubble ----
        rdy0 = 1'b1;
        tick();
        check("drain_pc0",   idp0, 32'h8);
        check("drain_ins0",  idi0, 32'hA4);
        check("drain_lvl0",  {30'h0, lvl0}, 32'd2);
        check("drain_addr0", addr0, 32'hC);
        tick();
        check("drain_pc1",   idp0, 32'hC);
        check("drain_ins1",  idi0, 32'hA8);
        check("drain_lvl1",  {30'h0, lvl0}, 32'd2);
        check("drain_addr1", addr0, 32'h10);
`ifdef IF_PERF_CNT_EN
        check("perf_stall3", stall0, 32'd3);
`endif

        // ---- branch at level 2 ----
        br0 = 1'b1; bra0 = 32'h103;
        tick();
        br0 = 1'b0;
        check("br_lvl",   {30'h0, lvl0}, 32'd0);
        check("br_valid", {31'h0, val0}, 32'h0);
        check("br_addr",  addr0, 32'h100);
        check("br_idpc",  idp0, 32'h0);
`ifdef IF_PERF_CNT_EN
        check("perf_flush1", flush0, 32'd1);
`endif
        tick();
        check("tgt_valid", {31'h0, val0}, 32'h1);
        check("tgt_pc",    idp0, 32'h104);
        check("tgt_instr", idi0, 32'h1A0);

        // ---- mid-stream reset at level 2 ----
        rdy0 = 1'b0;
        tick();
        tick();
        check("pre_rst_lvl", {30'h0, lvl0}, 32'd2);
`ifdef IF_PERF_CNT_EN
        check("perf_stall4", stall0, 32'd4);
`endif
        rst_n0 = 1'b0;
        tick();
        rst_n0 = 1'b1;
        check("mrst_addr",  addr0, 32'h0);
        check("mrst_valid", {31'h0, val0}, 32'h0);
        check("mrst_instr", idi0, 32'h0);
        check("mrst_pc",    idp0, 32'h0);
        check("mrst_lvl",   {30'h0, lvl0}, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("mrst_stall", stall0, 32'd0);
        check("mrst_flush", flush0, 32'd0);
`endif

        // ---- PC wrap from RESET_PC=0xFFFFFFF8 ----
        check("wrap_rst_addr", addr1, 32'hFFFF_FFF8);
        rst_n1 = 1'b1;
        tick();
        check("wrap_addr0",  addr1, 32'hFFFF_FFFC);
        check("wrap_pc0",    idp1, 32'hFFFF_FFFC);
        check("wrap_instr0", idi1, 32'h0000_0098);
        tick();
        check("wrap_addr1",  addr1, 32'h0);
        check("wrap_pc1",    idp1, 32'h0);
        check("wrap_valid1", {31'h0, val1}, 32'h1);
        check("wrap_instr1", idi1, 32'h0000_009C);
        tick();
        check("wrap_addr2",  addr1, 32'h4);
        check("wrap_pc2",    idp1, 32'h4);
        check("wrap_instr2", idi1, 32'h0000_00A0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_if_fetch_unit
`default_nettype wire
